// File: rtl/memory_bus_pkg.sv
// Shared address map and UART state encoding for the memory bus.
package memory_bus_pkg;

  localparam logic [31:0] GPIO_ADDR        = 32'h8000_0000;
  localparam logic [31:0] TIMER_ADDR       = 32'h8000_0004;
  localparam logic [31:0] UART_TX_ADDR     = 32'h8000_0008;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h8000_000C;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // Word match: the byte offset never takes part in decode.
  function automatic logic hit(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return addr[31:2] == base[31:2];
  endfunction

endpackage

// File: rtl/memory_bus_uart.sv
// 8N1 UART transmitter; busy for exactly one 10-bit frame.
module uart_tx_unit
  import memory_bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shreg, shreg_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      shreg   <= shreg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_idx;
    shreg_nx = shreg;
    tx       = 1'b1;
    busy     = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = START;
          cnt_nx   = '0;
          bit_nx   = '0;
          shreg_nx = tx_byte;
        end
      end
      START: begin
        tx = 1'b0;
        if (cnt == LAST) begin
          cnt_nx   = '0;
          state_nx = DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        tx = shreg[bit_idx];
        if (cnt == LAST) begin
          cnt_nx = '0;
          bit_nx = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/memory_bus.sv
// Core data bus: RAM, GPIO, free-running timer and UART TX.
module memory_bus
  import memory_bus_pkg::*;
#(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_out,
  input  logic        we,
  output logic [31:0] data_in,
  output logic [7:0]  gpio_out,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   mem [RAM_WORDS];
  logic [31:0]   timer;
  logic [31:0]   rd_val;
  logic [AW-1:0] idx;
  logic          is_ram;
  logic          sel_gpio, sel_timer;
  logic          sel_utx, sel_stat;
  logic          wr;
  logic          uart_busy;
  logic          unused_addr;

  assign idx       = address[AW+1:2];
  assign is_ram    = address[31:AW+2] == '0;
  assign sel_gpio  = hit(address, GPIO_ADDR);
  assign sel_timer = hit(address, TIMER_ADDR);
  assign sel_utx   = hit(address, UART_TX_ADDR);
  assign sel_stat  = hit(address, UART_STATUS_ADDR);
  assign wr        = we & ~reset;

  assign unused_addr = ^address[1:0];

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      is_ram:    rd_val = mem[idx];
      sel_gpio:  rd_val = {24'b0, gpio_out};
      sel_timer: rd_val = timer;
      sel_stat:  rd_val = {31'b0, uart_busy};
      default:   rd_val = '0;
    endcase
  end

  // RAM survives reset; only the bus registers are cleared.
  always_ff @(posedge clk) begin
    if (wr && is_ram) begin
      mem[idx] <= data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_in  <= '0;
      gpio_out <= '0;
      timer    <= '0;
    end else begin
      data_in <= rd_val;
      timer   <= timer + 32'd1;
      if (we && sel_gpio) begin
        gpio_out <= data_out[7:0];
      end
    end
  end

  uart_tx_unit #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk     (clk),
    .reset   (reset),
    .start   (wr & sel_utx & ~uart_busy),
    .tx_byte (data_out[7:0]),
    .tx      (uart_tx),
    .busy    (uart_busy)
  );

endmodule

// File: tb/tb_memory_bus.sv
// Bench for memory_bus: directed table, UART frames, random vs model.
module tb_memory_bus;

  localparam int CPB = 4;
  localparam int RW  = 1024;
  localparam int FRAME = 10 * CPB;

  localparam bit [31:0] A_GPIO  = 32'h8000_0000;
  localparam bit [31:0] A_TIMER = 32'h8000_0004;
  localparam bit [31:0] A_UTX   = 32'h8000_0008;
  localparam bit [31:0] A_STAT  = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] data_out = '0;
  logic        we = 1'b0;
  logic [31:0] data_in;
  logic [7:0]  gpio_out;
  logic        uart_tx;

  always #5 clk = ~clk;

  memory_bus #(
    .RAM_WORDS    (RW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .data_out (data_out),
    .we       (we),
    .data_in  (data_in),
    .gpio_out (gpio_out),
    .uart_tx  (uart_tx)
  );

  int checks = 0;
  int failures = 0;

  bit [31:0] m_ram [bit [31:0]];
  bit [7:0]  m_gpio = '0;
  bit [31:0] m_timer = '0;
  bit [31:0] m_data = '0;
  bit        m_data_ok = 1'b0;
  int        edge_n = 0;
  bit        f_act = 1'b0;
  int        f_start = 0;
  bit [7:0]  f_byte = '0;

  function automatic bit m_busy_after(int m);
    return f_act && (m - f_start) <= FRAME - 1;
  endfunction

  function automatic bit m_tx_after(int m);
    int k;
    if (!m_busy_after(m)) return 1'b1;
    k = (m - f_start) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return f_byte[k-1];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at edge %0d",
               name, act, exp, edge_n);
    end
  endtask

  task automatic step(bit rst, bit w, bit [31:0] a, bit [31:0] d);
    bit [31:0] wa;
    bit pre_busy;
    reset = rst;
    we = w;
    address = a;
    data_out = d;
    @(posedge clk);
    edge_n++;
    wa = a & 32'hFFFF_FFFC;
    pre_busy = m_busy_after(edge_n - 1);
    if (rst) begin
      m_data = '0;
      m_data_ok = 1'b1;
      m_gpio = '0;
      m_timer = '0;
      f_act = 1'b0;
    end else begin
      m_data = '0;
      m_data_ok = 1'b1;
      if (wa < 4 * RW) begin
        if (m_ram.exists(wa)) m_data = m_ram[wa];
        else m_data_ok = 1'b0;
      end else if (wa == A_GPIO) m_data = {24'b0, m_gpio};
      else if (wa == A_TIMER) m_data = m_timer;
      else if (wa == A_STAT) m_data = {31'b0, pre_busy};
      if (w) begin
        if (wa < 4 * RW) m_ram[wa] = d;
        else if (wa == A_GPIO) m_gpio = d[7:0];
        else if (wa == A_UTX && !pre_busy) begin
          f_act = 1'b1;
          f_start = edge_n;
          f_byte = d[7:0];
        end
      end
      m_timer++;
    end
    #1;
    if (m_data_ok) check("data_in", data_in, m_data);
    check("gpio_out", {24'b0, gpio_out}, {24'b0, m_gpio});
    check("uart_tx", {31'b0, uart_tx}, {31'b0, m_tx_after(edge_n)});
  endtask

  typedef struct {
    bit        rst;
    bit        w;
    bit [31:0] a;
    bit [31:0] d;
    bit        chk;
    bit [31:0] exp_data;
    bit [7:0]  exp_gpio;
  } vec_t;

  vec_t tv [13];

  initial begin
    bit [9:0] lv55;
    int ones;
    bit [31:0] a;
    int r;

    tv = '{
      '{1, 0, 32'h0,         32'h0,         1, 32'h0,         8'h00},
      '{1, 0, 32'h0,         32'h0,         1, 32'h0,         8'h00},
      '{0, 0, A_TIMER,       32'h0,         1, 32'h0,         8'h00},
      '{0, 1, 32'h0000_0010, 32'hDEADBEEF,  0, 32'h0,         8'h00},
      '{0, 0, 32'h0000_0013, 32'h0,         1, 32'hDEADBEEF,  8'h00},
      '{0, 0, 32'h0000_2000, 32'h0,         1, 32'h0,         8'h00},
      '{0, 1, A_GPIO,        32'hFFFF_FFA5, 1, 32'h0,         8'hA5},
      '{0, 0, A_GPIO + 2,    32'h0,         1, 32'h0000_00A5, 8'hA5},
      '{0, 0, A_TIMER,       32'h0,         1, 32'd6,         8'hA5},
      '{0, 0, A_UTX,         32'h0,         1, 32'h0,         8'hA5},
      '{0, 0, 32'h8000_0010, 32'h0,         1, 32'h0,         8'hA5},
      '{0, 1, A_TIMER,       32'h0,         1, 32'd9,         8'hA5},
      '{0, 0, A_TIMER,       32'h0,         1, 32'd10,        8'hA5}
    };

    for (int i = 0; i < 13; i++) begin
      step(tv[i].rst, tv[i].w, tv[i].a, tv[i].d);
      if (tv[i].chk) check("tv_data", data_in, tv[i].exp_data);
      check("tv_gpio", {24'b0, gpio_out}, {24'b0, tv[i].exp_gpio});
      if (tv[i].rst) check("tv_tx_idle", {31'b0, uart_tx}, 32'd1);
    end

    // Clean 0x55 frame: level per bit slot, busy counted via STATUS.
    lv55 = 10'b10_1010_1010;
    step(0, 1, A_UTX, 32'h0000_0055);
    check("f1_start", {31'b0, uart_tx}, 32'd0);
    ones = 0;
    for (int j = 1; j <= 45; j++) begin
      step(0, 0, A_STAT, 32'h0);
      if (data_in[0]) ones++;
      check("f1_tx", {31'b0, uart_tx},
            {31'b0, (j < FRAME) ? lv55[j / CPB] : 1'b1});
    end
    check("f1_busy_cycles", ones, FRAME);
    check("f1_status_idle", data_in, 32'h0);

    // Second frame with a 0x0F write landing while busy.
    step(0, 1, A_UTX, 32'h0000_0055);
    for (int j = 1; j <= 60; j++) begin
      if (j == 5) step(0, 1, A_UTX, 32'h0000_000F);
      else step(0, 0, A_STAT, 32'h0);
      check("f2_tx", {31'b0, uart_tx},
            {31'b0, (j < FRAME) ? lv55[j / CPB] : 1'b1});
    end
    check("f2_no_second", data_in, 32'h0);

    // Reset 12 cycles into a frame aborts it; RAM survives.
    step(0, 1, A_UTX, 32'h0000_00A3);
    for (int j = 1; j < 12; j++) step(0, 0, 32'h0, 32'h0);
    step(1, 1, A_GPIO, 32'h0000_00FF);
    check("rst_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_gpio", {24'b0, gpio_out}, 32'h0);
    step(0, 0, A_STAT, 32'h0);
    check("rst_busy", data_in, 32'h0);
    step(0, 0, 32'h0000_0010, 32'h0);
    check("rst_ram", data_in, 32'hDEADBEEF);

    for (int i = 0; i < 16; i++) begin
      step(0, 1, 32'(i * 4), $urandom);
    end

    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 35) a = 32'($urandom_range(0, 15) * 4);
      else if (r < 48) a = A_GPIO;
      else if (r < 58) a = A_TIMER;
      else if (r < 68) a = A_UTX;
      else if (r < 82) a = A_STAT;
      else if (r < 86) a = 32'h8000_0010;
      else if (r < 90) a = 32'h4000_0000;
      else if (r < 94) a = 32'h0000_1000;
      else a = 32'hFFFF_FFFC;
      a = a | 32'($urandom_range(0, 3));
      step($urandom_range(0, 79) == 0, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
